rename_map_table: RTL and testbench

Multi-lane register rename table for the out-of-order core, sitting between decode and dispatch. It renames RENAME_WIDTH instructions per cycle: speculative areg-to-preg map reads, intra-group dependency bypass, and old-destination-tag return. It also keeps per-preg ready bits updated by writeback, and a committed map that restores the speculative map on flush.

---
 rtl/rename_pkg.sv | 26 ++
 rtl/rename_map_table_if.sv | 46 ++++
 rtl/rmt_group_bypass.sv | 32 +++
 rtl/rename_map_table.sv | 133 +++++++++++++
 tb/tb_rename_map_table.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared widths, counts and tag/index types for the rename map table.
// Also provides the identity map loaded into both maps on reset.
package rename_pkg;

    localparam int PREG_WIDTH   = 6;
    localparam int AREG_WIDTH   = 5;
    localparam int NUM_AREG     = 32;
    localparam int NUM_PREG     = 64;
    localparam int RENAME_WIDTH = 2;
    localparam int WB_PORTS     = 2;
    localparam int COMMIT_WIDTH = 2;

    typedef logic [PREG_WIDTH-1:0] preg_tag_t;
    typedef logic [AREG_WIDTH-1:0] areg_idx_t;

    typedef preg_tag_t [NUM_AREG-1:0] map_t;

    function automatic map_t identity_map();
        map_t m;
        for (int k = 0; k < NUM_AREG; k++) begin
            m[k] = PREG_WIDTH'(k);
        end
        return m;
    endfunction

endpackage

// File: rtl/rename_map_table_if.sv
// Rename, writeback, commit and flush bundle of the rename map table.
// master: decode/ROB side driving requests; slave: the table itself.
interface rename_map_table_if;
    import rename_pkg::*;

    logic [RENAME_WIDTH-1:0]               rn_valid;
    areg_idx_t [RENAME_WIDTH-1:0]          rn_rs1_idx;
    areg_idx_t [RENAME_WIDTH-1:0]          rn_rs2_idx;
    areg_idx_t [RENAME_WIDTH-1:0]          rn_rd_idx;
    logic [RENAME_WIDTH-1:0]               rn_rd_we;
    preg_tag_t [RENAME_WIDTH-1:0]          rn_rd_tag;

    preg_tag_t [RENAME_WIDTH-1:0]          rs1_tag;
    preg_tag_t [RENAME_WIDTH-1:0]          rs2_tag;
    preg_tag_t [RENAME_WIDTH-1:0]          rd_old_tag;
    logic [RENAME_WIDTH-1:0]               rs1_ready;
    logic [RENAME_WIDTH-1:0]               rs2_ready;

    logic [WB_PORTS-1:0]                   wb_valid;
    preg_tag_t [WB_PORTS-1:0]              wb_tag;

    logic [COMMIT_WIDTH-1:0]               cm_valid;
    areg_idx_t [COMMIT_WIDTH-1:0]          cm_rd_idx;
    preg_tag_t [COMMIT_WIDTH-1:0]          cm_rd_tag;

    logic                                  flush;

    modport master (
        output rn_valid, rn_rs1_idx, rn_rs2_idx, rn_rd_idx,
        output rn_rd_we, rn_rd_tag,
        output wb_valid, wb_tag,
        output cm_valid, cm_rd_idx, cm_rd_tag,
        output flush,
        input  rs1_tag, rs2_tag, rd_old_tag, rs1_ready, rs2_ready
    );

    modport slave (
        input  rn_valid, rn_rs1_idx, rn_rs2_idx, rn_rd_idx,
        input  rn_rd_we, rn_rd_tag,
        input  wb_valid, wb_tag,
        input  cm_valid, cm_rd_idx, cm_rd_tag,
        input  flush,
        output rs1_tag, rs2_tag, rd_old_tag, rs1_ready, rs2_ready
    );

endinterface

// File: rtl/rmt_group_bypass.sv
// Intra-group bypass for one operand: younger lanes see the newest
// older-lane rd tag. Ports: src_idx/map_tag per lane in; tag/hit out.
module rmt_group_bypass
    import rename_pkg::*;
(
    input  areg_idx_t [RENAME_WIDTH-1:0] src_idx,
    input  preg_tag_t [RENAME_WIDTH-1:0] map_tag,
    input  logic [RENAME_WIDTH-1:0]      rn_valid,
    input  logic [RENAME_WIDTH-1:0]      rn_rd_we,
    input  areg_idx_t [RENAME_WIDTH-1:0] rn_rd_idx,
    input  preg_tag_t [RENAME_WIDTH-1:0] rn_rd_tag,
    output preg_tag_t [RENAME_WIDTH-1:0] tag,
    output logic [RENAME_WIDTH-1:0]      hit
);

    always_comb begin
        tag = map_tag;
        hit = '0;
        for (int j = 1; j < RENAME_WIDTH; j++) begin
            // ascending scan: the youngest older lane overrides last
            for (int i = 0; i < j; i++) begin
                if (rn_valid[i] && rn_rd_we[i] &&
                    rn_rd_idx[i] != '0 &&
                    rn_rd_idx[i] == src_idx[j]) begin
                    tag[j] = rn_rd_tag[i];
                    hit[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rename_map_table.sv
// Speculative/committed rename maps plus per-preg ready bits.
// Ports: clk, rst (sync, active high), bus (slave). Macro: RMT_WB_BYPASS_EN.
module rename_map_table
    import rename_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    rename_map_table_if.slave   bus
);

    map_t                spec_map;
    map_t                commit_map;
    logic [NUM_PREG-1:0] ready;

    map_t                spec_next;
    map_t                commit_next;
    logic [NUM_PREG-1:0] ready_next;

    preg_tag_t [RENAME_WIDTH-1:0] rs1_map;
    preg_tag_t [RENAME_WIDTH-1:0] rs2_map;
    preg_tag_t [RENAME_WIDTH-1:0] rd_map;
    logic [RENAME_WIDTH-1:0]      rs1_hit;
    logic [RENAME_WIDTH-1:0]      rs2_hit;
    logic [RENAME_WIDTH-1:0]      rd_hit;

    always_comb begin
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            rs1_map[j] = spec_map[bus.rn_rs1_idx[j]];
            rs2_map[j] = spec_map[bus.rn_rs2_idx[j]];
            rd_map[j]  = spec_map[bus.rn_rd_idx[j]];
        end
    end

    rmt_group_bypass u_byp_rs1 (
        .src_idx   (bus.rn_rs1_idx),
        .map_tag   (rs1_map),
        .rn_valid  (bus.rn_valid),
        .rn_rd_we  (bus.rn_rd_we),
        .rn_rd_idx (bus.rn_rd_idx),
        .rn_rd_tag (bus.rn_rd_tag),
        .tag       (bus.rs1_tag),
        .hit       (rs1_hit)
    );

    rmt_group_bypass u_byp_rs2 (
        .src_idx   (bus.rn_rs2_idx),
        .map_tag   (rs2_map),
        .rn_valid  (bus.rn_valid),
        .rn_rd_we  (bus.rn_rd_we),
        .rn_rd_idx (bus.rn_rd_idx),
        .rn_rd_tag (bus.rn_rd_tag),
        .tag       (bus.rs2_tag),
        .hit       (rs2_hit)
    );

    rmt_group_bypass u_byp_rd (
        .src_idx   (bus.rn_rd_idx),
        .map_tag   (rd_map),
        .rn_valid  (bus.rn_valid),
        .rn_rd_we  (bus.rn_rd_we),
        .rn_rd_idx (bus.rn_rd_idx),
        .rn_rd_tag (bus.rn_rd_tag),
        .tag       (bus.rd_old_tag),
        .hit       (rd_hit)
    );

    // rd_old never needs a ready bit
    logic unused_rd_hit;
    assign unused_rd_hit = ^rd_hit;

    always_comb begin
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            bus.rs1_ready[j] = ready[bus.rs1_tag[j]];
            bus.rs2_ready[j] = ready[bus.rs2_tag[j]];
`ifdef RMT_WB_BYPASS_EN
            for (int p = 0; p < WB_PORTS; p++) begin
                if (bus.wb_valid[p] && bus.wb_tag[p] == bus.rs1_tag[j])
                    bus.rs1_ready[j] = 1'b1;
                if (bus.wb_valid[p] && bus.wb_tag[p] == bus.rs2_tag[j])
                    bus.rs2_ready[j] = 1'b1;
            end
`endif
            // x0 is always ready; an in-group producer never is
            if (bus.rn_rs1_idx[j] == '0) bus.rs1_ready[j] = 1'b1;
            if (bus.rn_rs2_idx[j] == '0) bus.rs2_ready[j] = 1'b1;
            if (rs1_hit[j]) bus.rs1_ready[j] = 1'b0;
            if (rs2_hit[j]) bus.rs2_ready[j] = 1'b0;
        end
    end

    always_comb begin
        commit_next = commit_map;
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (bus.cm_valid[c] && bus.cm_rd_idx[c] != '0)
                commit_next[bus.cm_rd_idx[c]] = bus.cm_rd_tag[c];
        end
    end

    always_comb begin
        spec_next  = spec_map;
        ready_next = ready;
        if (bus.flush) begin
            spec_next  = commit_next;
            ready_next = '1;
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (bus.wb_valid[p])
                    ready_next[bus.wb_tag[p]] = 1'b1;
            end
            // applied after writeback so a rename clear wins
            for (int j = 0; j < RENAME_WIDTH; j++) begin
                if (bus.rn_valid[j] && bus.rn_rd_we[j] &&
                    bus.rn_rd_idx[j] != '0) begin
                    spec_next[bus.rn_rd_idx[j]] = bus.rn_rd_tag[j];
                    ready_next[bus.rn_rd_tag[j]] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_map   <= identity_map();
            commit_map <= identity_map();
            ready      <= '1;
        end else begin
            spec_map   <= spec_next;
            commit_map <= commit_next;
            ready      <= ready_next;
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Random + directed bench for rename_map_table against an array model.
// Honours RMT_WB_BYPASS_EN when the same macro is set for the bench.
module tb_rename_map_table;
    import rename_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rename_map_table_if bus ();

    rename_map_table dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int m_spec   [NUM_AREG];
    int m_commit [NUM_AREG];
    bit m_rdy    [NUM_PREG];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic idle();
        bus.rn_valid   = '0;
        bus.rn_rd_we   = '0;
        bus.rn_rs1_idx = '0;
        bus.rn_rs2_idx = '0;
        bus.rn_rd_idx  = '0;
        bus.rn_rd_tag  = '0;
        bus.wb_valid   = '0;
        bus.wb_tag     = '0;
        bus.cm_valid   = '0;
        bus.cm_rd_idx  = '0;
        bus.cm_rd_tag  = '0;
        bus.flush      = 1'b0;
    endtask

    function automatic bit writes(input int i);
        return bus.rn_valid[i] && bus.rn_rd_we[i] &&
               bus.rn_rd_idx[i] != 0;
    endfunction

    // expected tag/ready of areg idx as seen by lane j
    task automatic expect_src(input int j, input int idx,
                              output int tag, output int rdy);
        bit byp;
        tag = m_spec[idx];
        byp = 0;
        for (int i = 0; i < j; i++) begin
            if (writes(i) && int'(bus.rn_rd_idx[i]) == idx) begin
                tag = int'(bus.rn_rd_tag[i]);
                byp = 1;
            end
        end
        rdy = int'(m_rdy[tag]);
`ifdef RMT_WB_BYPASS_EN
        for (int p = 0; p < WB_PORTS; p++)
            if (bus.wb_valid[p] && int'(bus.wb_tag[p]) == tag) rdy = 1;
`endif
        if (idx == 0) rdy = 1;
        if (byp) rdy = 0;
    endtask

    task automatic check_all();
        int t;
        int r;
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            expect_src(j, int'(bus.rn_rs1_idx[j]), t, r);
            chk($sformatf("rs1_tag[%0d]", j), int'(bus.rs1_tag[j]), t);
            chk($sformatf("rs1_rdy[%0d]", j), int'(bus.rs1_ready[j]), r);
            expect_src(j, int'(bus.rn_rs2_idx[j]), t, r);
            chk($sformatf("rs2_tag[%0d]", j), int'(bus.rs2_tag[j]), t);
            chk($sformatf("rs2_rdy[%0d]", j), int'(bus.rs2_ready[j]), r);
            expect_src(j, int'(bus.rn_rd_idx[j]), t, r);
            chk($sformatf("rd_old[%0d]", j), int'(bus.rd_old_tag[j]), t);
        end
    endtask

    task automatic model_update();
        int cm [NUM_AREG];
        if (rst) begin
            for (int k = 0; k < NUM_AREG; k++) begin
                m_spec[k]   = k;
                m_commit[k] = k;
            end
            for (int k = 0; k < NUM_PREG; k++) m_rdy[k] = 1;
            return;
        end
        cm = m_commit;
        for (int c = 0; c < COMMIT_WIDTH; c++)
            if (bus.cm_valid[c] && bus.cm_rd_idx[c] != 0)
                cm[bus.cm_rd_idx[c]] = int'(bus.cm_rd_tag[c]);
        if (bus.flush) begin
            m_spec = cm;
            for (int k = 0; k < NUM_PREG; k++) m_rdy[k] = 1;
        end else begin
            for (int p = 0; p < WB_PORTS; p++)
                if (bus.wb_valid[p]) m_rdy[bus.wb_tag[p]] = 1;
            for (int i = 0; i < RENAME_WIDTH; i++)
                if (writes(i)) begin
                    m_spec[bus.rn_rd_idx[i]] = int'(bus.rn_rd_tag[i]);
                    m_rdy[bus.rn_rd_tag[i]] = 0;
                end
        end
        m_commit = cm;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    function automatic areg_idx_t rnd_idx();
        if ($urandom_range(0, 1) == 0)
            return AREG_WIDTH'($urandom_range(0, 7));
        return AREG_WIDTH'($urandom_range(0, NUM_AREG - 1));
    endfunction

    task automatic rnd_inputs();
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            bus.rn_valid[j]   = 1'($urandom_range(0, 3) != 0);
            bus.rn_rd_we[j]   = 1'($urandom_range(0, 3) != 0);
            bus.rn_rs1_idx[j] = rnd_idx();
            bus.rn_rs2_idx[j] = rnd_idx();
            bus.rn_rd_idx[j]  = rnd_idx();
            bus.rn_rd_tag[j]  = PREG_WIDTH'($urandom_range(0, NUM_PREG - 1));
        end
        for (int p = 0; p < WB_PORTS; p++) begin
            bus.wb_valid[p] = 1'($urandom_range(0, 1));
            bus.wb_tag[p]   = PREG_WIDTH'($urandom_range(0, NUM_PREG - 1));
        end
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            bus.cm_valid[c]  = 1'($urandom_range(0, 2) == 0);
            bus.cm_rd_idx[c] = rnd_idx();
            bus.cm_rd_tag[c] = PREG_WIDTH'($urandom_range(0, NUM_PREG - 1));
        end
        bus.flush = 1'($urandom_range(0, 39) == 0);
        rst       = 1'($urandom_range(0, 199) == 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // reset state lookups
        bus.rn_valid[0]   = 1'b1;
        bus.rn_rs1_idx[0] = 5'd5;
        bus.rn_rs2_idx[0] = 5'd0;
        bus.rn_rd_idx[0]  = 5'd7;
        #1;
        chk("rst_rs1_tag", int'(bus.rs1_tag[0]), 5);
        chk("rst_rs1_rdy", int'(bus.rs1_ready[0]), 1);
        chk("rst_rs2_tag", int'(bus.rs2_tag[0]), 0);
        chk("rst_rs2_rdy", int'(bus.rs2_ready[0]), 1);
        chk("rst_rd_old", int'(bus.rd_old_tag[0]), 7);
        check_all();
        tick();

        // intra-group bypass
        idle();
        bus.rn_valid     = 2'b11;
        bus.rn_rd_we     = 2'b11;
        bus.rn_rd_idx[0] = 5'd3;
        bus.rn_rd_tag[0] = 6'd40;
        bus.rn_rs1_idx[1] = 5'd3;
        bus.rn_rd_idx[1] = 5'd3;
        bus.rn_rd_tag[1] = 6'd41;
        #1;
        chk("byp_rs1_tag", int'(bus.rs1_tag[1]), 40);
        chk("byp_rs1_rdy", int'(bus.rs1_ready[1]), 0);
        chk("byp_rd_old", int'(bus.rd_old_tag[1]), 40);
        check_all();
        tick();
        idle();
        bus.rn_rs1_idx[0] = 5'd3;
        #1;
        chk("hi_lane_tag", int'(bus.rs1_tag[0]), 41);
        chk("hi_lane_rdy", int'(bus.rs1_ready[0]), 0);

        // writeback of 41
        bus.wb_valid[0] = 1'b1;
        bus.wb_tag[0]   = 6'd41;
        #1;
`ifdef RMT_WB_BYPASS_EN
        chk("wb_same_cyc", int'(bus.rs1_ready[0]), 1);
`else
        chk("wb_same_cyc", int'(bus.rs1_ready[0]), 0);
`endif
        tick();
        bus.wb_valid = '0;
        #1;
        chk("wb_next_cyc", int'(bus.rs1_ready[0]), 1);

        // rename, commit, rename, flush with same-cycle commits
        idle();
        bus.rn_valid[0] = 1'b1;
        bus.rn_rd_we[0] = 1'b1;
        bus.rn_rd_idx[0] = 5'd3;
        bus.rn_rd_tag[0] = 6'd40;
        tick();
        idle();
        bus.cm_valid[0]  = 1'b1;
        bus.cm_rd_idx[0] = 5'd3;
        bus.cm_rd_tag[0] = 6'd40;
        tick();
        idle();
        bus.rn_valid[0] = 1'b1;
        bus.rn_rd_we[0] = 1'b1;
        bus.rn_rd_idx[0] = 5'd3;
        bus.rn_rd_tag[0] = 6'd50;
        tick();
        idle();
        bus.flush = 1'b1;
        bus.cm_valid     = 2'b11;
        bus.cm_rd_idx[0] = 5'd8;
        bus.cm_rd_tag[0] = 6'd50;
        bus.cm_rd_idx[1] = 5'd10;
        bus.cm_rd_tag[1] = 6'd60;
        bus.rn_valid[0] = 1'b1;
        bus.rn_rd_we[0] = 1'b1;
        bus.rn_rd_idx[0] = 5'd11;
        bus.rn_rd_tag[0] = 6'd33;
        tick();
        idle();
        bus.rn_rs1_idx[0] = 5'd3;
        bus.rn_rs2_idx[0] = 5'd8;
        bus.rn_rd_idx[0]  = 5'd11;
        #1;
        chk("fl_rs1_tag", int'(bus.rs1_tag[0]), 40);
        chk("fl_rs1_rdy", int'(bus.rs1_ready[0]), 1);
        chk("fl_rs2_tag", int'(bus.rs2_tag[0]), 50);
        chk("fl_rs2_rdy", int'(bus.rs2_ready[0]), 1);
        chk("fl_discard", int'(bus.rd_old_tag[0]), 11);

        // rd=0 rename is ignored
        idle();
        bus.rn_valid     = 2'b11;
        bus.rn_rd_we[0]  = 1'b1;
        bus.rn_rd_idx[0] = 5'd0;
        bus.rn_rd_tag[0] = 6'd60;
        bus.rn_rs1_idx[1] = 5'd0;
        #1;
        chk("x0_no_byp", int'(bus.rs1_tag[1]), 0);
        chk("x0_rdy", int'(bus.rs1_ready[1]), 1);
        tick();
        idle();
        bus.rn_rs1_idx[0] = 5'd0;
        bus.rn_rs2_idx[0] = 5'd10;
        #1;
        chk("x0_map", int'(bus.rs1_tag[0]), 0);
        chk("p60_tag", int'(bus.rs2_tag[0]), 60);
        chk("p60_rdy", int'(bus.rs2_ready[0]), 1);

        // rename during reset is discarded
        idle();
        rst = 1'b1;
        bus.rn_valid[0] = 1'b1;
        bus.rn_rd_we[0] = 1'b1;
        bus.rn_rd_idx[0] = 5'd4;
        bus.rn_rd_tag[0] = 6'd45;
        tick();
        rst = 1'b0;
        idle();
        bus.rn_rs1_idx[0] = 5'd4;
        #1;
        chk("rst_disc_tag", int'(bus.rs1_tag[0]), 4);
        chk("rst_disc_rdy", int'(bus.rs1_ready[0]), 1);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rnd_inputs();
            #1;
            check_all();
            tick();
        end
        rst = 1'b0;
        idle();
        #1;
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
